// File: rtl/renkon_pkg.sv
// Shared definitions for the renkon convolution-stage controller: core FSM
// encodings, the start/valid/stop control bundle and default datapath latencies.
package renkon_pkg;

    localparam logic [1:0] S_CORE_WAIT    = 2'd0;
    localparam logic [1:0] S_CORE_NETWORK = 2'd1;
    localparam logic [1:0] S_CORE_INPUT   = 2'd2;
    localparam logic [1:0] S_CORE_OUTPUT  = 2'd3;

    localparam int DEF_D_CONV  = 2;
    localparam int DEF_D_ACCUM = 1;

    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg;

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETUP,
        S_ACTIVE,
        S_DONE
    } conv_state_e;

endpackage

// File: rtl/renkon_ctrl_delay.sv
// Generic fixed-depth shift pipe used to align control strobes and addresses
// with the convolution and accumulation datapath latencies. DEPTH of 0 is a wire.
module renkon_ctrl_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one stage per clock; reset empties the whole pipe at once
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/renkon_ctrl_conv_stride.sv
// Convolution-stage controller with programmable stride. Computes the output
// feature size by repeated subtraction, turns the input pixel stream into
// window-valid strobes and feature-buffer commands, then sweeps the buffer out.
module renkon_ctrl_conv_stride
    import renkon_pkg::*;
#(
    parameter int LWIDTH  = 12,
    parameter int SWIDTH  = 3,
    parameter int FACCUM  = 10,
    parameter int D_CONV  = DEF_D_CONV,
    parameter int D_ACCUM = DEF_D_ACCUM
) (
    input  logic              clk,
    input  logic              rst,
    input  ctrl_reg           in_ctrl,
    input  logic [1:0]        core_state,
    input  logic [LWIDTH-1:0] w_img_size,
    input  logic [LWIDTH-1:0] w_conv_size,
    input  logic [SWIDTH-1:0] w_stride,
    input  logic              first_input,
    input  logic              last_input,
    output ctrl_reg           out_ctrl,
    output logic              mem_feat_we,
    output logic              mem_feat_rst,
    output logic [FACCUM-1:0] mem_feat_raddr,
    output logic [FACCUM-1:0] mem_feat_waddr,
    output logic              conv_oe,
    output logic [LWIDTH-1:0] w_fea_size,
    output logic              cfg_ready,
    output logic              cfg_err
);

    localparam int D_OUT = D_CONV + D_ACCUM;

    conv_state_e       state;
    logic [1:0]        core_q;
    logic [LWIDTH-1:0] img, conv, rem, quo;
    logic [LWIDTH-1:0] in_x, in_y, out_x, out_y;
    logic [SWIDTH-1:0] stride, ph_x, ph_y;
    logic [FACCUM-1:0] feat_addr;

    logic [LWIDTH-1:0] stride_ext, img_m1, conv_m1, fea_m1;
    logic [SWIDTH-1:0] ph_x_next, ph_y_next;
    logic              cfg_bad, in_take, x_wrap, last_pix, win_v, last_win;
    logic              in_phase, sweep_v, sweep_last;
    logic [1:0]        we_pipe;
    logic [2:0]        oe_pipe, out_pipe;

    // Window detection, sweep position and configuration legality
    assign stride_ext = LWIDTH'(stride);
    assign img_m1     = img - LWIDTH'(1);
    assign conv_m1    = conv - LWIDTH'(1);
    assign fea_m1     = w_fea_size - LWIDTH'(1);
    assign cfg_bad    = (w_stride == '0) || (w_conv_size == '0) || (w_conv_size > w_img_size);
    assign in_phase   = (state == S_ACTIVE) && (core_q == S_CORE_INPUT);
    assign in_take    = in_phase && in_ctrl.valid;
    assign x_wrap     = (in_x == img_m1);
    assign last_pix   = x_wrap && (in_y == img_m1);
    assign win_v      = in_take && (in_x >= conv_m1) && (in_y >= conv_m1) &&
                        (ph_x == '0) && (ph_y == '0);
    assign last_win   = in_take && last_pix && last_input;
    assign sweep_v    = (state == S_ACTIVE) && (core_q == S_CORE_OUTPUT);
    assign sweep_last = sweep_v && (out_x == fea_m1) && (out_y == fea_m1);
    assign ph_x_next  = (ph_x == stride - SWIDTH'(1)) ? '0 : ph_x + SWIDTH'(1);
    assign ph_y_next  = (ph_y == stride - SWIDTH'(1)) ? '0 : ph_y + SWIDTH'(1);

    // Main FSM: configuration latch, setup divider, raster/phase counters and output sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_WAIT;
            core_q     <= S_CORE_WAIT;
            img        <= '0;
            conv       <= '0;
            stride     <= '0;
            rem        <= '0;
            quo        <= '0;
            in_x       <= '0;
            in_y       <= '0;
            ph_x       <= '0;
            ph_y       <= '0;
            out_x      <= '0;
            out_y      <= '0;
            feat_addr  <= '0;
            w_fea_size <= '0;
            cfg_ready  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            core_q <= core_state;
            case (state)
                S_WAIT, S_DONE: begin
                    feat_addr <= '0;
                    if (in_ctrl.start) begin
                        img       <= w_img_size;
                        conv      <= w_conv_size;
                        stride    <= w_stride;
                        rem       <= w_img_size - w_conv_size;
                        quo       <= '0;
                        cfg_ready <= 1'b0;
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                            state   <= S_WAIT;
                        end else begin
                            cfg_err <= 1'b0;
                            state   <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    if (rem >= stride_ext) begin
                        rem <= rem - stride_ext;
                        quo <= quo + LWIDTH'(1);
                    end else begin
                        w_fea_size <= quo + LWIDTH'(1);
                        cfg_ready  <= 1'b1;
                        state      <= S_ACTIVE;
                        in_x       <= '0;
                        in_y       <= '0;
                        ph_x       <= '0;
                        ph_y       <= '0;
                        out_x      <= '0;
                        out_y      <= '0;
                        feat_addr  <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (in_take) begin
                        if (x_wrap) begin
                            in_x <= '0;
                            ph_x <= '0;
                            if (in_y == img_m1) begin
                                in_y <= '0;
                                ph_y <= '0;
                            end else begin
                                in_y <= in_y + LWIDTH'(1);
                                if (in_y >= conv_m1) ph_y <= ph_y_next;
                            end
                        end else begin
                            in_x <= in_x + LWIDTH'(1);
                            if (in_x >= conv_m1) ph_x <= ph_x_next;
                        end
                    end
                    if (in_phase && in_ctrl.stop) begin
                        feat_addr <= '0;
                    end else if (win_v) begin
                        feat_addr <= feat_addr + FACCUM'(1);
                    end else if (sweep_v) begin
                        feat_addr <= sweep_last ? '0 : feat_addr + FACCUM'(1);
                    end
                    if (sweep_v) begin
                        if (sweep_last) begin
                            out_x <= '0;
                            out_y <= '0;
                            state <= S_DONE;
                        end else if (out_x == fea_m1) begin
                            out_x <= '0;
                            out_y <= out_y + LWIDTH'(1);
                        end else begin
                            out_x <= out_x + LWIDTH'(1);
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    renkon_ctrl_delay #(.WIDTH(2), .DEPTH(D_CONV)) u_we_dly (
        .clk(clk), .rst(rst), .d({win_v, win_v & first_input}), .q(we_pipe)
    );

    renkon_ctrl_delay #(.WIDTH(FACCUM), .DEPTH(D_CONV - 1)) u_raddr_dly (
        .clk(clk), .rst(rst), .d(feat_addr), .q(mem_feat_raddr)
    );

    renkon_ctrl_delay #(.WIDTH(FACCUM), .DEPTH(1)) u_waddr_dly (
        .clk(clk), .rst(rst), .d(mem_feat_raddr), .q(mem_feat_waddr)
    );

    renkon_ctrl_delay #(.WIDTH(3), .DEPTH(D_OUT - 1)) u_oe_dly (
        .clk(clk), .rst(rst), .d({last_win, sweep_v, sweep_last}), .q(oe_pipe)
    );

    renkon_ctrl_delay #(.WIDTH(3), .DEPTH(1)) u_out_dly (
        .clk(clk), .rst(rst), .d(oe_pipe), .q(out_pipe)
    );

    assign mem_feat_we  = we_pipe[1];
    assign mem_feat_rst = we_pipe[0];
    assign conv_oe      = oe_pipe[1];
    assign out_ctrl     = ctrl_reg'(out_pipe);

endmodule

// File: tb/tb_renkon_ctrl_conv_stride.sv
// Self-checking bench for renkon_ctrl_conv_stride: setup-vector table, directed
// multi-channel/stride/bubble/reset sequences and randomized jobs against a
// behavioural model of window positions, write addresses and output sweep timing.
module tb_renkon_ctrl_conv_stride;
    import renkon_pkg::*;

    localparam int LW = 12;
    localparam int SW = 3;
    localparam int FA = 10;
    localparam int DC = 2;
    localparam int DA = 1;
    localparam int DT = DC + DA;

    logic          clk = 1'b0;
    logic          rst;
    ctrl_reg       in_ctrl, out_ctrl;
    logic [1:0]    core_state;
    logic [LW-1:0] w_img_size, w_conv_size, w_fea_size;
    logic [SW-1:0] w_stride;
    logic          first_input, last_input;
    logic          mem_feat_we, mem_feat_rst, conv_oe, cfg_ready, cfg_err;
    logic [FA-1:0] mem_feat_raddr, mem_feat_waddr;

    typedef struct {
        int addr;
        bit rst;
        int cyc;
    } wr_t;

    typedef struct {
        int img;
        int conv;
        int stride;
        int fea;
        bit err;
    } setup_vec_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    wr_t wq[$];
    int  wr_count = 0, valid_count = 0, stop_count = 0, start_count = 0;
    bit  sweep_armed = 0, start_armed = 0;
    int  sweep_s = 0, sweep_total = 0, exp_start_cyc = 0;

    renkon_ctrl_conv_stride #(
        .LWIDTH(LW), .SWIDTH(SW), .FACCUM(FA), .D_CONV(DC), .D_ACCUM(DA)
    ) dut (
        .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .core_state(core_state),
        .w_img_size(w_img_size), .w_conv_size(w_conv_size), .w_stride(w_stride),
        .first_input(first_input), .last_input(last_input), .out_ctrl(out_ctrl),
        .mem_feat_we(mem_feat_we), .mem_feat_rst(mem_feat_rst),
        .mem_feat_raddr(mem_feat_raddr), .mem_feat_waddr(mem_feat_waddr),
        .conv_oe(conv_oe), .w_fea_size(w_fea_size), .cfg_ready(cfg_ready),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Feature-buffer write scoreboard: every write must match the model in order and time
    always @(negedge clk) begin : wr_mon
        wr_t e;
        if (mem_feat_we) begin
            wr_count++;
            if (wq.size() == 0) begin
                checkOutput("unexpected_we", 1, 0);
            end else begin
                e = wq.pop_front();
                checkOutput("we_time", cyc, e.cyc);
                checkOutput("waddr", mem_feat_waddr, e.addr);
                checkOutput("we_rst", mem_feat_rst, e.rst);
            end
        end else if (mem_feat_rst) begin
            checkOutput("rst_without_we", 1, 0);
        end
    end

    // Output-sweep monitor: valid/stop/conv_oe/raddr windows and out_ctrl.start timing
    always @(negedge clk) begin : out_mon
        int idx, ridx;
        bit ev, eo, es, est;
        idx  = cyc - (sweep_s + DT);
        ridx = cyc - (sweep_s + DC - 1);
        ev   = sweep_armed && (idx >= 0) && (idx < sweep_total);
        eo   = sweep_armed && (idx >= -1) && (idx <= sweep_total - 2);
        es   = ev && (idx == sweep_total - 1);
        est  = start_armed && (cyc == exp_start_cyc);
        if (out_ctrl.valid) valid_count++;
        if (out_ctrl.stop)  stop_count++;
        if (out_ctrl.start) start_count++;
        if (out_ctrl.valid || ev) checkOutput("out_valid", out_ctrl.valid, ev);
        if (conv_oe || eo)        checkOutput("conv_oe", conv_oe, eo);
        if (out_ctrl.stop || es)  checkOutput("out_stop", out_ctrl.stop, es);
        if (out_ctrl.start || est) checkOutput("out_start", out_ctrl.start, est);
        if (sweep_armed && (ridx >= 0) && (ridx < sweep_total))
            checkOutput("sweep_raddr", mem_feat_raddr, ridx);
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_we"}, mem_feat_we, 0);
        checkOutput({tag, "_rst"}, mem_feat_rst, 0);
        checkOutput({tag, "_raddr"}, mem_feat_raddr, 0);
        checkOutput({tag, "_waddr"}, mem_feat_waddr, 0);
        checkOutput({tag, "_conv_oe"}, conv_oe, 0);
        checkOutput({tag, "_out_ctrl"}, out_ctrl, 0);
        checkOutput({tag, "_fea"}, w_fea_size, 0);
        checkOutput({tag, "_ready"}, cfg_ready, 0);
        checkOutput({tag, "_err"}, cfg_err, 0);
    endtask

    task automatic doReset();
        rst         = 1'b1;
        in_ctrl     = '0;
        core_state  = S_CORE_WAIT;
        first_input = 1'b0;
        last_input  = 1'b0;
        sweep_armed = 1'b0;
        start_armed = 1'b0;
        wq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulseStart(input int img, input int conv, input int stride);
        w_img_size    = LW'(img);
        w_conv_size   = LW'(conv);
        w_stride      = SW'(stride);
        in_ctrl.start = 1'b1;
        @(posedge clk);
        #1;
        in_ctrl.start = 1'b0;
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (!cfg_ready && n < 4100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // One complete job: setup, nch input channels through the model, then output sweep.
    // bubble: 0 none, 1 one idle cycle before every third pixel, 2 random idles.
    // abort_at >= 0 asserts rst during that sweep element instead of finishing.
    task automatic applyStimulus(input int img, input int conv, input int stride,
                                 input int nch, input int bubble, input int abort_at);
        int fea, k, n, p, wr0, v0, s0, st0;
        wr_t e;
        fea = (img - conv) / stride + 1;
        wr0 = wr_count;
        st0 = start_count;
        pulseStart(img, conv, stride);
        checkOutput("cfg_err_clear", cfg_err, 0);
        waitReady(n);
        checkOutput("setup_cycles", n, fea);
        checkOutput("fea_size", w_fea_size, fea);
        core_state = S_CORE_INPUT;
        @(posedge clk);
        #1;
        k = 0;
        for (int c = 0; c < nch; c++) begin
            first_input = (c == 0);
            last_input  = (c == nch - 1);
            for (int y = 0; y < img; y++) begin
                for (int x = 0; x < img; x++) begin
                    p = y * img + x;
                    if ((bubble == 1 && p % 3 == 2) ||
                        (bubble == 2 && $urandom_range(0, 3) == 0)) begin
                        @(posedge clk);
                        #1;
                    end
                    in_ctrl.valid = 1'b1;
                    in_ctrl.stop  = (x == img - 1) && (y == img - 1);
                    if (x >= conv - 1 && y >= conv - 1 &&
                        (x - (conv - 1)) % stride == 0 && (y - (conv - 1)) % stride == 0) begin
                        e.addr = k;
                        e.rst  = (c == 0);
                        e.cyc  = cyc + DC;
                        wq.push_back(e);
                        k++;
                    end
                    if (in_ctrl.stop) begin
                        k = 0;
                        if (c == nch - 1) begin
                            exp_start_cyc = cyc + DT;
                            start_armed   = 1'b1;
                        end
                    end
                    @(posedge clk);
                    #1;
                    in_ctrl.valid = 1'b0;
                    in_ctrl.stop  = 1'b0;
                end
            end
        end
        first_input = 1'b0;
        last_input  = 1'b0;
        repeat (DT + 3) @(posedge clk);
        #1;
        checkOutput("pending_writes", wq.size(), 0);
        checkOutput("write_count", wr_count - wr0, nch * fea * fea);
        checkOutput("start_count", start_count - st0, 1);
        start_armed = 1'b0;
        v0          = valid_count;
        s0          = stop_count;
        sweep_s     = cyc + 1;
        sweep_total = fea * fea;
        sweep_armed = 1'b1;
        core_state  = S_CORE_OUTPUT;
        if (abort_at >= 0) begin
            repeat (abort_at + 1) @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            sweep_armed = 1'b0;
            core_state  = S_CORE_WAIT;
            checkAllZero("abort");
            rst = 1'b0;
            repeat (DT + 4) @(posedge clk);
            #1;
            checkOutput("abort_stop_count", stop_count - s0, 0);
        end else begin
            repeat (fea * fea + DT + 3) @(posedge clk);
            #1;
            core_state = S_CORE_WAIT;
            checkOutput("valid_count", valid_count - v0, fea * fea);
            checkOutput("stop_count", stop_count - s0, 1);
            sweep_armed = 1'b0;
        end
    endtask

    initial begin : main
        setup_vec_t tbl [10];
        int n, img, conv, stride, nch;

        tbl[0] = '{img: 12,  conv: 5, stride: 1, fea: 8,  err: 1'b0};
        tbl[1] = '{img: 12,  conv: 5, stride: 2, fea: 4,  err: 1'b0};
        tbl[2] = '{img: 13,  conv: 4, stride: 3, fea: 4,  err: 1'b0};
        tbl[3] = '{img: 8,   conv: 8, stride: 1, fea: 1,  err: 1'b0};
        tbl[4] = '{img: 12,  conv: 1, stride: 7, fea: 2,  err: 1'b0};
        tbl[5] = '{img: 20,  conv: 4, stride: 5, fea: 4,  err: 1'b0};
        tbl[6] = '{img: 100, conv: 3, stride: 1, fea: 98, err: 1'b0};
        tbl[7] = '{img: 5,   conv: 6, stride: 1, fea: 0,  err: 1'b1};
        tbl[8] = '{img: 8,   conv: 0, stride: 1, fea: 0,  err: 1'b1};
        tbl[9] = '{img: 8,   conv: 3, stride: 0, fea: 0,  err: 1'b1};

        w_img_size  = '0;
        w_conv_size = '0;
        w_stride    = '0;
        doReset();
        checkAllZero("reset");

        $display("[TB] setup vector table");
        for (int i = 0; i < 10; i++) begin
            doReset();
            pulseStart(tbl[i].img, tbl[i].conv, tbl[i].stride);
            if (tbl[i].err) begin
                checkOutput("tbl_err", cfg_err, 1);
                checkOutput("tbl_err_ready", cfg_ready, 0);
                repeat (3) @(posedge clk);
                #1;
                checkOutput("tbl_err_hold", cfg_err, 1);
                checkOutput("tbl_err_noready", cfg_ready, 0);
            end else begin
                checkOutput("tbl_no_err", cfg_err, 0);
                waitReady(n);
                checkOutput("tbl_setup_cycles", n, tbl[i].fea);
                checkOutput("tbl_fea", w_fea_size, tbl[i].fea);
            end
        end

        $display("[TB] illegal start then legal stride-1 job");
        doReset();
        pulseStart(5, 6, 1);
        checkOutput("illegal_err", cfg_err, 1);
        checkOutput("illegal_ready", cfg_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("illegal_ready_hold", cfg_ready, 0);
        applyStimulus(12, 5, 1, 1, 0, -1);

        $display("[TB] stride 2, stride 3 with bubbles, three channels");
        applyStimulus(12, 5, 2, 1, 0, -1);
        applyStimulus(13, 4, 3, 1, 1, -1);
        applyStimulus(9, 3, 2, 3, 0, -1);

        $display("[TB] reset mid-sweep then fresh run");
        applyStimulus(12, 5, 1, 1, 0, 20);
        applyStimulus(10, 3, 1, 2, 0, -1);

        $display("[TB] randomized jobs");
        for (int r = 0; r < 6; r++) begin
            img    = $urandom_range(3, 12);
            conv   = $urandom_range(1, img);
            stride = $urandom_range(1, 5);
            nch    = $urandom_range(1, 2);
            applyStimulus(img, conv, stride, nch, 2, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
